// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Size codes, FSM state encodings and the default bus timeout.
package dmem_access_unit_pkg;

    localparam logic [1:0] MEMSZ_N = 2'b00;
    localparam logic [1:0] MEMSZ_B = 2'b01;
    localparam logic [1:0] MEMSZ_H = 2'b10;
    localparam logic [1:0] MEMSZ_W = 2'b11;

    localparam int DMEM_TIMEOUT = 16;

    typedef enum logic [1:0] {
        DMEM_IDLE  = 2'b00,
        DMEM_REQ   = 2'b01,
        DMEM_RESP  = 2'b10,
        DMEM_FAULT = 2'b11
    } dmem_state_e;

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane select with sign or zero extension.
// Purely combinational so a future cache path can share it.
module dmem_load_ext
    import dmem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [1:0]      size,
    input  logic            lunsigned,
    output logic [XLEN-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    // pick the addressed byte/half and fill the upper bits
    always_comb begin
        b    = word[{lane, 3'b000} +: 8];
        h    = word[{lane[1], 4'b0000} +: 16];
        data = word;
        case (size)
            MEMSZ_B: data = {{(XLEN-8){~lunsigned & b[7]}}, b};
            MEMSZ_H: data = {{(XLEN-16){~lunsigned & h[15]}}, h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store responder: one word-aligned req/ack
// transaction per access, pipeline stall, misalign and timeout faults.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            memwrite,
    input  logic            memtoreg,
    input  logic [1:0]      lwhb,
    input  logic [1:0]      swhb,
    input  logic            lunsigned,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            misalign,
    output logic            bus_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    dmem_state_e state, state_d;

    logic            accept;
    logic [1:0]      eff_sz;
    logic            bad;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wd_d;

    logic [CW-1:0]   cnt;
    logic            flt_bus;
    logic [1:0]      ld_lane;
    logic [1:0]      ld_size;
    logic            ld_uns;
    logic [XLEN-1:0] rword;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] ext_data;

    // decode the incoming request: store wins, alignment, lanes
    always_comb begin
        accept = req_valid && (memwrite || memtoreg);
        eff_sz = memwrite ? swhb : lwhb;
        bad    = (eff_sz == MEMSZ_N)
              || (eff_sz == MEMSZ_H && addr[0])
              || (eff_sz == MEMSZ_W && addr[1:0] != 2'b00);
        be_d   = 4'b0000;
        wd_d   = wdata;
        case (eff_sz)
            MEMSZ_B: begin
                be_d = 4'b0001 << addr[1:0];
                wd_d = {(XLEN/8){wdata[7:0]}};
            end
            MEMSZ_H: begin
                be_d = 4'b0011 << {addr[1], 1'b0};
                wd_d = {(XLEN/16){wdata[15:0]}};
            end
            MEMSZ_W: begin
                be_d = 4'b1111;
                wd_d = wdata;
            end
            default: begin
                be_d = 4'b0000;
                wd_d = wdata;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= DMEM_IDLE;
        else        state <= state_d;
    end

    // next state and handshake/status outputs
    always_comb begin
        state_d  = state;
        stall    = 1'b0;
        done     = 1'b0;
        misalign = 1'b0;
        bus_err  = 1'b0;
        bus_req  = 1'b0;
        case (state)
            DMEM_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = bad ? DMEM_FAULT : DMEM_REQ;
                end
            end
            DMEM_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_ack)              state_d = DMEM_RESP;
                else if (cnt == CNT_LAST) state_d = DMEM_FAULT;
            end
            DMEM_RESP: begin
                done    = 1'b1;
                state_d = DMEM_IDLE;
            end
            DMEM_FAULT: begin
                misalign = ~flt_bus;
                bus_err  = flt_bus;
                state_d  = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // bus registers, timeout counter, load capture and result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            flt_bus   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
            ld_lane   <= 2'b00;
            ld_size   <= 2'b00;
            ld_uns    <= 1'b0;
            rword     <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        flt_bus <= 1'b0;
                        if (!bad) begin
                            bus_addr  <= {addr[XLEN-1:2], 2'b00};
                            bus_we    <= memwrite;
                            bus_be    <= be_d;
                            bus_wdata <= wd_d;
                            ld_lane   <= addr[1:0];
                            ld_size   <= eff_sz;
                            ld_uns    <= lunsigned;
                        end
                    end
                end
                DMEM_REQ: begin
                    if (bus_ack)              rword   <= bus_rdata;
                    else if (cnt == CNT_LAST) flt_bus <= 1'b1;
                    else                      cnt     <= cnt + CW'(1);
                end
                DMEM_RESP: begin
                    if (!bus_we) rdata_q <= ext_data;
                end
                default: ;
            endcase
        end
    end

    dmem_load_ext #(.XLEN(XLEN)) u_ext (
        .word      (rword),
        .lane      (ld_lane),
        .size      (ld_size),
        .lunsigned (ld_uns),
        .data      (ext_data)
    );

    // the fresh load result is visible in the done cycle, then held
    always_comb begin
        rdata = rdata_q;
        if (state == DMEM_RESP && !bus_we) rdata = ext_data;
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit (TIMEOUT = 4).
// Expected values are hand-computed constants.
module tb_dmem_access_unit;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid, memwrite, memtoreg, lunsigned;
    logic [1:0]      lwhb, swhb;
    logic [XLEN-1:0] addr, wdata;
    logic            stall, done, misalign, bus_err;
    logic [XLEN-1:0] rdata;
    logic            bus_req, bus_we, bus_ack;
    logic [XLEN-1:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]      bus_be;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] last_rd = 32'h0;

    dmem_access_unit #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .memwrite(memwrite), .memtoreg(memtoreg),
        .lwhb(lwhb), .swhb(swhb), .lunsigned(lunsigned),
        .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata),
        .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
        lwhb = 2'b00; swhb = 2'b00; lunsigned = 1'b0;
        addr = '0; wdata = '0;
    endtask

    task automatic drive(input logic st, input logic both, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        memwrite  = st;
        memtoreg  = ~st | both;
        swhb      = st ? sz : 2'b00;
        lwhb      = st ? 2'b01 : sz;
        lunsigned = uns;
        addr      = a;
        wdata     = wd;
    endtask

    // one complete access with `waits` non-ack REQ cycles
    task automatic access(input string nm, input logic st, input logic both,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rw, input int waits,
                          input logic [31:0] ea, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        @(negedge clk);
        drive(st, both, sz, uns, a, wd);
        #1;
        chk({nm, ".stall0"}, stall, 1);
        chk({nm, ".req0"}, bus_req, 0);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k <= waits; k++) begin
            if (k > 0) @(negedge clk);
            chk({nm, ".req"}, bus_req, 1);
            chk({nm, ".stall"}, stall, 1);
            chk({nm, ".done_early"}, done, 0);
            chk({nm, ".addr"}, bus_addr, ea);
            chk({nm, ".be"}, bus_be, ebe);
            chk({nm, ".we"}, bus_we, st);
            chk({nm, ".wdata"}, bus_wdata, ewd);
            bus_ack   = (k == waits);
            bus_rdata = (k == waits) ? rw : ~rw;
        end
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        chk({nm, ".done"}, done, 1);
        chk({nm, ".stall_resp"}, stall, 0);
        chk({nm, ".req_resp"}, bus_req, 0);
        chk({nm, ".rdata"}, rdata, erd);
        @(negedge clk);
        chk({nm, ".done_pulse"}, done, 0);
        chk({nm, ".rdata_hold"}, rdata, erd);
        last_rd = erd;
    endtask

    // access rejected in IDLE: misalign pulse, no bus activity
    task automatic fault_access(input string nm, input logic st,
                                input logic [1:0] sz, input logic [31:0] a);
        @(negedge clk);
        drive(st, 1'b0, sz, 1'b0, a, 32'h0);
        #1;
        chk({nm, ".stall0"}, stall, 1);
        @(negedge clk);
        idle_inputs();
        chk({nm, ".misalign"}, misalign, 1);
        chk({nm, ".bus_err"}, bus_err, 0);
        chk({nm, ".req"}, bus_req, 0);
        chk({nm, ".stall1"}, stall, 0);
        chk({nm, ".done"}, done, 0);
        chk({nm, ".rdata"}, rdata, last_rd);
        @(negedge clk);
        chk({nm, ".misalign_pulse"}, misalign, 0);
        chk({nm, ".req2"}, bus_req, 0);
    endtask

    initial begin
        reset = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        idle_inputs();
        #12;
        chk("rst.stall", stall, 0);
        chk("rst.done", done, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.misalign", misalign, 0);
        chk("rst.bus_err", bus_err, 0);
        chk("rst.req", bus_req, 0);
        chk("rst.we", bus_we, 0);
        chk("rst.addr", bus_addr, 0);
        chk("rst.be", bus_be, 0);
        chk("rst.wdata", bus_wdata, 0);
        @(negedge clk);
        reset = 1'b1;

        access("sw", 1, 0, 2'b11, 0, 32'h104, 32'hDEADBEEF, 32'h0, 0,
               32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
        access("sb", 1, 0, 2'b01, 0, 32'h203, 32'h000000A5, 32'h0, 0,
               32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0);
        access("lb", 0, 0, 2'b01, 0, 32'h101, 32'h0, 32'h1234F678, 0,
               32'h100, 4'b0010, 32'h0, 32'hFFFFFFF6);
        access("lbu", 0, 0, 2'b01, 1, 32'h101, 32'h0, 32'h1234F678, 0,
               32'h100, 4'b0010, 32'h0, 32'h000000F6);
        access("lh", 0, 0, 2'b10, 0, 32'h102, 32'h0, 32'h80010000, 3,
               32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
        access("lhu", 0, 0, 2'b10, 1, 32'h100, 32'h0, 32'hABCD8001, 1,
               32'h100, 4'b0011, 32'h0, 32'h00008001);
        access("lw", 0, 0, 2'b11, 0, 32'h108, 32'h0, 32'h89ABCDEF, 0,
               32'h108, 4'b1111, 32'h0, 32'h89ABCDEF);
        access("sh", 1, 0, 2'b10, 0, 32'h106, 32'h1234BEEF, 32'h0, 0,
               32'h104, 4'b1100, 32'hBEEFBEEF, 32'h89ABCDEF);
        access("sw_ld", 1, 1, 2'b11, 0, 32'h110, 32'hCAFEF00D, 32'h0, 0,
               32'h110, 4'b1111, 32'hCAFEF00D, 32'h89ABCDEF);

        fault_access("lw_mis", 0, 2'b11, 32'h102);
        fault_access("ld_sz0", 0, 2'b00, 32'h100);
        fault_access("sh_mis", 1, 2'b10, 32'h101);

        // no request qualifier: no stall, no bus activity; stray ack ignored
        @(negedge clk);
        req_valid = 1'b1; addr = 32'h100; lwhb = 2'b11;
        bus_ack = 1'b1;
        #1;
        chk("noop.stall", stall, 0);
        @(negedge clk);
        idle_inputs();
        chk("noop.req", bus_req, 0);
        chk("noop.done", done, 0);
        bus_ack = 1'b0;

        // bus timeout: TO REQ cycles without ack, then one bus_err pulse
        @(negedge clk);
        drive(0, 0, 2'b11, 0, 32'h10C, 32'h0);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < TO; k++) begin
            if (k > 0) @(negedge clk);
            chk("to.req", bus_req, 1);
            chk("to.err_early", bus_err, 0);
        end
        @(negedge clk);
        chk("to.bus_err", bus_err, 1);
        chk("to.req_drop", bus_req, 0);
        chk("to.misalign", misalign, 0);
        chk("to.done", done, 0);
        chk("to.stall", stall, 0);
        chk("to.rdata", rdata, last_rd);
        @(negedge clk);
        chk("to.err_pulse", bus_err, 0);

        // asynchronous reset in the middle of REQ
        @(negedge clk);
        drive(0, 0, 2'b11, 0, 32'h10C, 32'h0);
        @(negedge clk);
        idle_inputs();
        chk("ar.req_before", bus_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar.req", bus_req, 0);
        chk("ar.stall", stall, 0);
        chk("ar.addr", bus_addr, 0);
        chk("ar.rdata", rdata, 0);
        last_rd = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        access("sw_post", 1, 0, 2'b11, 0, 32'h104, 32'h13579BDF, 32'h0, 0,
               32'h104, 4'b1111, 32'h13579BDF, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
